dff_pipeline: RTL and testbench

DFF_PIPELINE -- requirements
Module: dff_pipeline

---
 rtl/dff_pipeline_pkg.sv | 11 +
 rtl/dff_pipe_stage.sv | 33 +++
 rtl/dff_pipeline.sv | 77 +++++++
 tb/tb_dff_pipeline.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipeline_pkg.sv
// rtl/dff_pipeline_pkg.sv - shared defaults and width helpers for the dff pipeline
package dff_pipeline_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one data+valid register stage of the dff pipeline
module dff_pipe_stage
    import dff_pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_drop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
);

    // Data only changes on load or clear; a departing word just drops its valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q     <= '0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            o_q     <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_q     <= i_d;
            o_valid <= 1'b1;
        end else if (i_drop) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dff_pipeline.sv
// rtl/dff_pipeline.sv - elastic register pipeline with bubble collapsing and flush
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [WIDTH-1:0]                i_D,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [WIDTH-1:0]                o_Q,
    output logic [WIDTH-1:0]                o_Qn,
    output logic                            o_valid,
    input  logic                            i_ready,
    input  logic                            i_flush,
    output logic [count_width(DEPTH)-1:0]   o_count
);

    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] recv;

    // Walk from the output back so each stage sees whether its successor frees up.
    always_comb begin
        move = '0;
        recv = '0;
        move[DEPTH-1] = valid[DEPTH-1] && i_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move[k] = valid[k] && (!valid[k+1] || move[k+1]);
        end
        o_ready = (!valid[0] || move[0]) && !i_flush;
        recv[0] = i_valid && o_ready;
        for (int k = 1; k < DEPTH; k++) begin
            recv[k] = move[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;

        if (k == 0) begin : g_head
            assign d_in = i_D;
        end else begin : g_body
            assign d_in = stage_q[k-1];
        end

        dff_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (recv[k]),
            .i_drop  (move[k]),
            .i_clear (i_flush),
            .i_d     (d_in),
            .o_q     (stage_q[k]),
            .o_valid (valid[k])
        );
    end

    assign o_Q     = stage_q[DEPTH-1];
    assign o_Qn    = ~stage_q[DEPTH-1];
    assign o_valid = valid[DEPTH-1];

    always_comb begin
        o_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_count = o_count + CW'(valid[k]);
        end
    end

endmodule

// File: tb/tb_dff_pipeline.sv
// tb/tb_dff_pipeline.sv - scoreboard bench for dff_pipeline
module tb_dff_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_D;
    logic       i_valid, i_ready, i_flush;
    logic       o_ready, o_valid;
    logic [7:0] o_Q, o_Qn;
    logic [2:0] o_count;

    logic       d1_D, d1_valid, d1_ready, d1_flush;
    logic       d1_o_ready, d1_o_Q, d1_o_Qn, d1_o_valid;
    logic [0:0] d1_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    dff_pipeline #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_D (i_D), .i_valid (i_valid),
        .o_ready (o_ready), .o_Q (o_Q), .o_Qn (o_Qn), .o_valid (o_valid),
        .i_ready (i_ready), .i_flush (i_flush), .o_count (o_count)
    );

    dff_pipeline #(.WIDTH(1), .DEPTH(1)) dut1 (
        .i_clk (clk), .i_rst_n (rst_n), .i_D (d1_D), .i_valid (d1_valid),
        .o_ready (d1_o_ready), .o_Q (d1_o_Q), .o_Qn (d1_o_Qn), .o_valid (d1_o_valid),
        .i_ready (d1_ready), .i_flush (d1_flush), .o_count (d1_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every transfer out must match the oldest outstanding word.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {24'd0, o_Q}, 32'hFFFF_FFFF);
            end else begin
                check("out_data", {24'd0, o_Q}, {24'd0, exp_q.pop_front()});
            end
            n_out++;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted v.
    task automatic drive_word(input logic [7:0] v);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        i_D     = v;
        i_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                exp_q.push_back(v);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 20) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n    = 1'b0;
        i_D      = '0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_flush  = 1'b0;
        d1_D     = 1'b0;
        d1_valid = 1'b0;
        d1_ready = 1'b0;
        d1_flush = 1'b0;

        #3;
        check("rst_q",     {24'd0, o_Q},  32'h00);
        check("rst_qn",    {24'd0, o_Qn}, 32'hFF);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_count", {29'd0, o_count}, 32'd0);
        check("d1_rst_qn", {31'd0, d1_o_Qn}, 32'd1);
        #19;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency through an empty DEPTH=4 pipe
        i_ready = 1'b1;
        drive_word(8'hA5);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            if (e < 3) begin
                check("lat_early_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                check("lat_valid", {31'd0, o_valid}, 32'd1);
                check("lat_q",     {24'd0, o_Q},  32'hA5);
                check("lat_qn",    {24'd0, o_Qn}, 32'h5A);
            end
        end
        @(posedge clk);
        #1;
        wait_drain();

        // Backpressure: four fit, the fifth stalls
        i_ready = 1'b0;
        base    = n_out;
        for (int v = 1; v <= 4; v++) drive_word(8'(v));
        i_D     = 8'h05;
        i_valid = 1'b1;
        @(negedge clk);
        check("bp_ready",  {31'd0, o_ready}, 32'd0);
        check("bp_count",  {29'd0, o_count}, 32'd4);
        check("bp_hold_q", {24'd0, o_Q}, 32'h01);
        @(posedge clk);
        #1;
        check("bp_hold_q2", {24'd0, o_Q}, 32'h01);
        i_ready = 1'b1;
        drive_word(8'h05);
        wait_drain();
        check("bp_out_count", n_out - base, 32'd5);

        // Full-rate throughput
        i_ready = 1'b0;
        for (int v = 0; v < 4; v++) drive_word(8'(8'h20 + v));
        check("tp_full", {29'd0, o_count}, 32'd4);
        i_ready = 1'b1;
        base    = n_out;
        for (int i = 0; i < 20; i++) begin
            i_D     = 8'(8'h30 + i);
            i_valid = 1'b1;
            @(negedge clk);
            check("tp_ready", {31'd0, o_ready}, 32'd1);
            check("tp_count", {29'd0, o_count}, 32'd4);
            if (o_ready) exp_q.push_back(i_D);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        check("tp_out_count", n_out - base, 32'd20);
        wait_drain();

        // Flush beats a simultaneous offer
        i_ready = 1'b0;
        for (int v = 0; v < 3; v++) drive_word(8'(8'h41 + v));
        check("fl_pre_count", {29'd0, o_count}, 32'd3);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_D     = 8'h77;
        @(negedge clk);
        check("fl_ready", {31'd0, o_ready}, 32'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        check("fl_count", {29'd0, o_count}, 32'd0);
        check("fl_q",     {24'd0, o_Q},  32'h00);
        check("fl_qn",    {24'd0, o_Qn}, 32'hFF);
        check("fl_valid", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of traffic
        i_ready = 1'b0;
        drive_word(8'h61);
        drive_word(8'h62);
        i_D     = 8'h99;
        i_valid = 1'b1;
        i_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mr_q",     {24'd0, o_Q},  32'h00);
        check("mr_qn",    {24'd0, o_Qn}, 32'hFF);
        check("mr_valid", {31'd0, o_valid}, 32'd0);
        check("mr_count", {29'd0, o_count}, 32'd0);
        i_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("mr_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;

        // DEPTH=1, WIDTH=1 instance
        d1_D     = 1'b1;
        d1_valid = 1'b1;
        @(negedge clk);
        check("d1_ready", {31'd0, d1_o_ready}, 32'd1);
        @(posedge clk);
        #1;
        d1_valid = 1'b0;
        check("d1_q",     {31'd0, d1_o_Q},     32'd1);
        check("d1_qn",    {31'd0, d1_o_Qn},    32'd0);
        check("d1_valid", {31'd0, d1_o_valid}, 32'd1);
        check("d1_count", {31'd0, d1_count},   32'd1);
        d1_ready = 1'b1;
        @(negedge clk);
        check("d1_ready_full_drain", {31'd0, d1_o_ready}, 32'd1);
        @(posedge clk);
        #1;
        d1_ready = 1'b0;
        check("d1_empty", {31'd0, d1_o_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
